// File: rtl/ndro_seq_pkg.sv
// ndro_seq_pkg: op codes, FSM states and the latched response record shared by the NDRO bank sequencer.
package ndro_seq_pkg;
  typedef enum logic [1:0] {OP_SET = 2'd0, OP_RESET = 2'd1, OP_READ = 2'd2, OP_RSVD = 2'd3} op_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_Q, S_GUARD} state_e;
  typedef struct packed {
    logic data;
    logic err;
  } rsp_t;
endpackage

// File: rtl/ndro_rr_arbiter.sv
// ndro_rr_arbiter: one-hot round-robin grant; search starts at the requester after the last accepted one.
module ndro_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   gid_o
);
  logic [IW-1:0] ptr_q, ptr_d, idx;
  // walk from lowest to highest priority so the last hit is the winner
  always_comb begin
    grant_o = '0;
    gid_o   = '0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (valid_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        gid_o        = idx;
      end
    end
    ptr_d = accept_i ? IW'((int'(gid_o) + 1) % NREQ) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/ndro_bank_sequencer.sv
// ndro_bank_sequencer: issues arbitrated SET/RESET/READ ops to a shared NDRO bank as single-transition
// pulses with guard spacing, tracks expected cell state and checks q readback.
module ndro_bank_sequencer
  import ndro_seq_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int GUARD_CYC = 2,
  parameter int Q_WAIT    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [AW*NREQ-1:0]      req_addr,
  output logic [NREQ-1:0]         req_ready,
  output logic [DEPTH-1:0]        a_tgl,
  output logic [DEPTH-1:0]        b_tgl,
  output logic [DEPTH-1:0]        clk_tgl,
  input  logic [DEPTH-1:0]        q_tgl,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_data,
  output logic                    rsp_err,
  output logic                    stray_err,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2((GUARD_CYC > Q_WAIT ? GUARD_CYC : Q_WAIT) + 1);
  state_e           state_q, state_d;
  op_e              op_in, op_q;
  rsp_t             rsp_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    gid, id_q;
  logic [AW-1:0]    addr_in;
  logic [DEPTH-1:0] sel_in, sel_q, shadow_q, a_q, b_q, c_q, hist_q, chg;
  logic             accept, ok_in, ok_q, seen_q, hit, hist_vld_q, stray_q;

  ndro_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (req_valid),
    .accept_i (accept),
    .grant_o  (grant),
    .gid_o    (gid)
  );

  always_comb begin
    op_in   = OP_SET;
    addr_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_in   = gid == IW'(i) ? op_e'(req_op[2*i +: 2]) : op_in;
      addr_in = gid == IW'(i) ? req_addr[AW*i +: AW] : addr_in;
    end
  end

  assign accept = state_q == S_IDLE && |grant;
  assign ok_in  = op_in != OP_RSVD && int'(addr_in) < DEPTH;
  assign sel_in = ok_in ? DEPTH'(1) << addr_in : '0;
  // history is not trusted until one clean sample has been taken after reset
  assign chg    = hist_vld_q ? q_tgl ^ hist_q : '0;
  assign hit    = |(chg & sel_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        state_d = ok_q && op_q == OP_READ ? S_WAIT_Q : S_GUARD;
        cnt_d   = state_d == S_WAIT_Q ? CW'(Q_WAIT - 1) : CW'(GUARD_CYC - 1);
      end
      S_WAIT_Q: begin
        state_d = cnt_q == '0 ? S_GUARD : S_WAIT_Q;
        cnt_d   = cnt_q == '0 ? CW'(GUARD_CYC - 1) : cnt_q - 1'b1;
      end
      default: begin
        state_d = cnt_q == '0 ? S_IDLE : S_GUARD;
        cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  // pulse lines flip on the accept edge so the transition is visible during ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      op_q       <= OP_SET;
      ok_q       <= 1'b0;
      sel_q      <= '0;
      shadow_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      seen_q     <= 1'b0;
      stray_q    <= 1'b0;
      rsp_q      <= '0;
    end else begin
      hist_q     <= q_tgl;
      hist_vld_q <= 1'b1;
      stray_q    <= stray_q | |(chg & ~(state_q == S_WAIT_Q ? sel_q : '0));
      if (accept) begin
        id_q     <= gid;
        op_q     <= op_in;
        ok_q     <= ok_in;
        sel_q    <= sel_in;
        a_q      <= a_q ^ (op_in == OP_SET ? sel_in : '0);
        b_q      <= b_q ^ (op_in == OP_RESET ? sel_in : '0);
        c_q      <= c_q ^ (op_in == OP_READ ? sel_in : '0);
        shadow_q <= op_in == OP_SET ? shadow_q | sel_in :
                    op_in == OP_RESET ? shadow_q & ~sel_in : shadow_q;
      end
      if (state_q == S_ISSUE) begin
        seen_q <= 1'b0;
        rsp_q  <= '{data: 1'b0, err: !ok_q};
      end
      if (state_q == S_WAIT_Q) begin
        seen_q <= seen_q | hit;
        rsp_q  <= '{data: seen_q | hit, err: (seen_q | hit) != |(shadow_q & sel_q)};
      end
    end
  end

  assign req_ready = state_q == S_IDLE ? grant : '0;
  assign a_tgl     = a_q;
  assign b_tgl     = b_q;
  assign clk_tgl   = c_q;
  assign busy      = state_q != S_IDLE;
  assign rsp_valid = state_q == S_GUARD && cnt_q == '0;
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign rsp_data  = rsp_valid & rsp_q.data;
  assign rsp_err   = rsp_valid & rsp_q.err;
  assign stray_err = stray_q;
endmodule

// File: tb/tb_ndro_bank_sequencer.sv
// tb_ndro_bank_sequencer: randomized and directed traffic checked against a transaction-timeline model
// of grants, pulse lines, shadow state, read windows and response timing.
module tb_ndro_bank_sequencer;
  localparam int NREQ = 4, DEPTH = 8, AW = 4, G = 2, QW = 3;
  localparam int IW = $clog2(NREQ), DW = $clog2(DEPTH);
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [AW*NREQ-1:0]  req_addr;
  logic [DEPTH-1:0]    a_tgl, b_tgl, clk_tgl, q_tgl;
  logic                rsp_valid, rsp_data, rsp_err, stray_err, busy;
  logic [IW-1:0]       rsp_id;

  always #5 clk = ~clk;

  ndro_bank_sequencer #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .GUARD_CYC(G), .Q_WAIT(QW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .a_tgl     (a_tgl),
    .b_tgl     (b_tgl),
    .clk_tgl   (clk_tgl),
    .q_tgl     (q_tgl),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .stray_err (stray_err),
    .busy      (busy)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, rr, idle_from, last_pulse, q_flip_cyc, q_flip_cell;
  int p_rsp, p_id, p_ws, p_we, p_cell;
  bit [DEPTH-1:0] a_m, b_m, c_m, sh_m, q_drv;
  bit [3*DEPTH-1:0] prev_lines;
  bit stray_m, p_on, p_rd, p_data, p_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rr = 0;
    idle_from = 0;
    last_pulse = -100;
    q_flip_cyc = -1;
    a_m = '0;
    b_m = '0;
    c_m = '0;
    sh_m = '0;
    prev_lines = '0;
    stray_m = 1'b0;
    p_on = 1'b0;
  endtask

  // fop/fad >= 0 force every requester's op/addr; qmode 0 random q reply, 1 reply 2 cycles after pulse, 2 none
  task automatic tick(input logic [NREQ-1:0] v, input int bad_pct, input int fop, input int fad, input int qmode);
    logic [DEPTH-1:0] qchg, mask;
    logic [NREQ-1:0]  g;
    logic [1:0]       op;
    int               gi, ad;
    bit               rv, ok, inwin;
    @(posedge clk);
    #1;
    cyc++;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2] = fop >= 0 ? 2'(fop) :
                         ($urandom_range(99) < bad_pct ? 2'd3 : 2'($urandom_range(2)));
      req_addr[AW*i +: AW] = fad >= 0 ? AW'(fad) :
                             ($urandom_range(99) < bad_pct ? AW'($urandom_range(15, 8)) : AW'($urandom_range(7)));
    end
    qchg = '0;
    if (cyc == q_flip_cyc) qchg[DW'(q_flip_cell)] = 1'b1;
    q_drv ^= qchg;
    q_tgl = q_drv;
    inwin = p_on && p_rd && cyc >= p_ws && cyc <= p_we;
    if (inwin && qchg[DW'(p_cell)]) p_data = 1'b1;
    g = '0;
    gi = -1;
    if (cyc >= idle_from)
      for (int k = NREQ - 1; k >= 0; k--) if (v[IW'((rr + k) % NREQ)]) gi = (rr + k) % NREQ;
    if (gi >= 0) g[IW'(gi)] = 1'b1;
    rv = p_on && cyc == p_rsp;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(g));
    check("busy", 32'(busy), 32'(cyc < idle_from));
    check("a_tgl", 32'(a_tgl), 32'(a_m));
    check("b_tgl", 32'(b_tgl), 32'(b_m));
    check("clk_tgl", 32'(clk_tgl), 32'(c_m));
    check("rsp_valid", 32'(rsp_valid), 32'(rv));
    check("rsp_id", 32'(rsp_id), rv ? 32'(p_id) : 32'd0);
    check("rsp_data", 32'(rsp_data), 32'(rv && p_data));
    check("rsp_err", 32'(rsp_err), 32'(rv && (p_rd ? p_data != sh_m[DW'(p_cell)] : p_bad)));
    check("stray_err", 32'(stray_err), 32'(stray_m));
    if ({a_tgl, b_tgl, clk_tgl} != prev_lines) begin
      check("pulse_spacing", 32'(cyc - last_pulse > G), 32'd1);
      last_pulse = cyc;
      prev_lines = {a_tgl, b_tgl, clk_tgl};
    end
    mask = inwin ? DEPTH'(1) << p_cell : '0;
    if ((qchg & ~mask) != '0) stray_m = 1'b1;
    if (rv) p_on = 1'b0;
    if (gi >= 0) begin
      op = req_op[2*gi +: 2];
      ad = int'(req_addr[AW*gi +: AW]);
      ok = op != 2'd3 && ad < DEPTH;
      rr = (gi + 1) % NREQ;
      p_on = 1'b1;
      p_id = gi;
      p_rd = ok && op == 2'd2;
      p_data = 1'b0;
      p_bad = !ok;
      p_cell = ok ? ad : 0;
      p_ws = cyc + 2;
      p_we = cyc + 1 + QW;
      p_rsp = cyc + 1 + G + (p_rd ? QW : 0);
      idle_from = p_rsp + 1;
      if (ok && op == 2'd0) begin
        a_m[DW'(ad)] ^= 1'b1;
        sh_m[DW'(ad)] = 1'b1;
      end
      if (ok && op == 2'd1) begin
        b_m[DW'(ad)] ^= 1'b1;
        sh_m[DW'(ad)] = 1'b0;
      end
      if (p_rd) c_m[DW'(ad)] ^= 1'b1;
      if (p_rd && (qmode == 1 || (qmode == 0 && $urandom_range(1) == 1))) begin
        q_flip_cyc = cyc + 1 + (qmode == 1 ? 2 : int'($urandom_range(1, QW)));
        q_flip_cell = ad;
      end
    end
  endtask

  task automatic drain();
    while (cyc < idle_from) tick('0, 0, -1, -1, 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_op = '0;
    req_addr = '0;
    q_drv = DEPTH'($urandom);
    q_tgl = q_drv;
    model_reset();
    #3;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_lines", 32'({a_tgl, b_tgl, clk_tgl}), 32'd0);
    check("reset_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_err}), 32'd0);
    check("reset_flags", 32'({stray_err, busy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // SET cell 2, then READ cell 2 with q answering two cycles after the read pulse
    tick(4'b0001, 0, 0, 2, 2);
    drain();
    tick(4'b0001, 0, 2, 2, 1);
    drain();
    // READ cell 5 without and with a q answer (shadow is 0, so the answer is an error)
    tick(4'b0010, 0, 2, 5, 2);
    drain();
    tick(4'b0010, 0, 2, 5, 1);
    drain();
    // out-of-range address and reserved op
    tick(4'b0100, 0, 0, 9, 2);
    drain();
    tick(4'b1000, 0, 3, 1, 2);
    drain();
    repeat (40) tick(4'b1111, 0, -1, -1, 0);
    repeat (1500) tick(NREQ'($urandom), 10, -1, -1, 0);
    drain();
    // q activity while idle must latch the sticky stray flag
    q_flip_cyc = cyc + 1;
    q_flip_cell = 1;
    repeat (6) tick('0, 0, -1, -1, 2);
    // reset during WAIT_Q
    tick(4'b0001, 0, 2, 3, 2);
    tick('0, 0, -1, -1, 2);
    tick('0, 0, -1, -1, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_lines", 32'({a_tgl, b_tgl, clk_tgl}), 32'd0);
    check("midrst_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_err}), 32'd0);
    check("midrst_flags", 32'({stray_err, busy}), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) tick(4'b1111, 0, -1, -1, 0);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
